// File: rtl/apb_cmd_arbiter.sv
// Round-robin arbiter that shares one APB_TOP command port among NREQ requesters.
// A captured command is issued, completed (or timed out), and answered with a done pulse.
module apb_cmd_arbiter #(
  parameter int NREQ      = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int XFER_HOLD = 2,
  parameter int TIMEOUT   = 16
) (
  input  logic                       PCLK,
  input  logic                       PRESETn,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0]            req_write,
  input  logic [NREQ*ADDR_W-1:0]     req_addr,
  input  logic [NREQ*DATA_W-1:0]     req_wdata,
  input  logic [NREQ*(DATA_W/8)-1:0] req_strb,
  output logic [NREQ-1:0]            gnt,
  output logic [NREQ-1:0]            done,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       rsp_err,
  output logic                       busy,
  output logic                       transfer,
  output logic                       read,
  output logic                       write,
  output logic [DATA_W/8-1:0]        WSTRB,
  output logic [ADDR_W-1:0]          apb_waddr,
  output logic [ADDR_W-1:0]          apb_raddr,
  output logic [DATA_W-1:0]          apb_wdata,
  input  logic [DATA_W-1:0]          apb_rdata,
  input  logic                       error,
  input  logic                       apb_done
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HC_W   = $clog2(XFER_HOLD + 1);
  localparam int TO_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state, state_next;
  logic [IDX_W-1:0]    rr_ptr, win, pick_idx, cand;
  logic                pick_valid;
  logic                lat_write;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [STRB_W-1:0]   lat_strb;
  logic [HC_W-1:0]     hold_cnt;
  logic [TO_W-1:0]     to_cnt;
  logic                cmpl;
  logic [DATA_W-1:0]   cap_rdata;
  logic                cap_err;
  logic [NREQ-1:0]     win_oh;

  // Descending scan so the requester closest to rr_ptr is the last (winning) assignment.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NREQ);
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else          state <= state_next;
  end

  // Completion is taken from the registered cmpl flag, so an apb_done seen in ISSUE also counts.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_valid) state_next = ISSUE;
      ISSUE:   if (hold_cnt == HC_W'(XFER_HOLD - 1)) state_next = WAIT;
      WAIT:    if (cmpl || (to_cnt == TO_W'(TIMEOUT - 1))) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rr_ptr    <= '0;
      win       <= '0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_strb  <= '0;
      hold_cnt  <= '0;
      to_cnt    <= '0;
      cmpl      <= 1'b0;
      cap_rdata <= '0;
      cap_err   <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            win       <= pick_idx;
            rr_ptr    <= (pick_idx == IDX_W'(NREQ - 1)) ? '0 : pick_idx + IDX_W'(1);
            lat_write <= req_write[pick_idx];
            lat_addr  <= req_addr[pick_idx*ADDR_W +: ADDR_W];
            lat_wdata <= req_wdata[pick_idx*DATA_W +: DATA_W];
            lat_strb  <= req_strb[pick_idx*STRB_W +: STRB_W];
            hold_cnt  <= '0;
            to_cnt    <= '0;
            cmpl      <= 1'b0;
            cap_rdata <= '0;
            cap_err   <= 1'b0;
          end
        end
        ISSUE: begin
          hold_cnt <= hold_cnt + HC_W'(1);
          to_cnt   <= '0;
          if (apb_done) begin
            cmpl      <= 1'b1;
            cap_rdata <= lat_write ? '0 : apb_rdata;
            cap_err   <= error;
          end
        end
        WAIT: begin
          to_cnt <= to_cnt + TO_W'(1);
          if (apb_done) begin
            cmpl      <= 1'b1;
            cap_rdata <= lat_write ? '0 : apb_rdata;
            cap_err   <= error;
          end
          if (state_next == RESP) begin
            rsp_rdata <= cmpl ? cap_rdata : '0;
            rsp_err   <= cmpl ? cap_err : 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign win_oh    = NREQ'(1) << win;
  assign busy      = (state != IDLE);
  assign gnt       = busy ? win_oh : '0;
  assign done      = (state == RESP) ? win_oh : '0;
  assign transfer  = (state == ISSUE);
  assign write     = (state == ISSUE) && lat_write;
  assign read      = (state == ISSUE) && !lat_write;
  assign WSTRB     = (busy && lat_write) ? lat_strb : '0;
  assign apb_wdata = (busy && lat_write) ? lat_wdata : '0;
  assign apb_waddr = (busy && lat_write) ? lat_addr : '0;
  assign apb_raddr = (busy && !lat_write) ? lat_addr : '0;

endmodule

// File: tb/tb_apb_cmd_arbiter.sv
// Directed bench for apb_cmd_arbiter: each scenario task drives its own stimulus and checks
// against hand-computed cycle counts and values.
module tb_apb_cmd_arbiter;
  localparam int NREQ = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int XFER_HOLD = 2;
  localparam int TIMEOUT = 16;

  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  logic [NREQ-1:0] req = '0, req_write = '0;
  logic [NREQ*ADDR_W-1:0] req_addr = '0;
  logic [NREQ*DATA_W-1:0] req_wdata = '0;
  logic [NREQ*(DATA_W/8)-1:0] req_strb = '0;
  logic [NREQ-1:0] gnt, done;
  logic [DATA_W-1:0] rsp_rdata, apb_wdata;
  logic rsp_err, busy, transfer, read, write;
  logic [DATA_W/8-1:0] WSTRB;
  logic [ADDR_W-1:0] apb_waddr, apb_raddr;
  logic [DATA_W-1:0] apb_rdata = '0;
  logic error = 1'b0;
  logic apb_done = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  // results of serve()
  int xn, dc, dn, gb;
  logic [NREQ-1:0] dv;
  logic [DATA_W-1:0] rdv;
  logic rev;

  apb_cmd_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                    .XFER_HOLD(XFER_HOLD), .TIMEOUT(TIMEOUT)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .req(req), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .gnt(gnt), .done(done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .transfer(transfer), .read(read), .write(write),
    .WSTRB(WSTRB), .apb_waddr(apb_waddr), .apb_raddr(apb_raddr),
    .apb_wdata(apb_wdata), .apb_rdata(apb_rdata), .error(error),
    .apb_done(apb_done)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [3:0] s);
    req[i] = 1'b1;
    req_write[i] = wr;
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_wdata[i*DATA_W +: DATA_W] = d;
    req_strb[i*4 +: 4] = s;
  endtask

  // Plays APB_TOP from the first ISSUE cycle (c=0): pulses apb_done in cycle pc (never if pc<0)
  // and records what the arbiter did up to the cycle after done.
  task automatic serve(input int pc, input logic [DATA_W-1:0] rd, input logic e);
    xn = 0; dc = -1; dn = 0; gb = 0; dv = '0; rdv = '0; rev = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (transfer) xn++;
      if (!$onehot0(gnt)) gb++;
      if (done != '0) begin
        dn++;
        if (dc < 0) begin
          dc = c; dv = done; rdv = rsp_rdata; rev = rsp_err;
        end
      end
      if (dc >= 0 && c == dc + 1) break;
      apb_done = (pc >= 0) && (c == pc);
      apb_rdata = apb_done ? rd : '0;
      error = apb_done ? e : 1'b0;
      tick();
    end
    apb_done = 1'b0; apb_rdata = '0; error = 1'b0;
  endtask

  task automatic test_reset();
    PRESETn = 1'b0;
    #12;
    n_cmp++; if (gnt !== 2'b00) begin n_bad++; $display("FAIL rst_gnt got=%h exp=0", gnt); end
    n_cmp++; if (done !== 2'b00) begin n_bad++; $display("FAIL rst_done got=%h exp=0", done); end
    n_cmp++; if ({busy, transfer, read, write, rsp_err} !== 5'b0) begin n_bad++; $display("FAIL rst_ctl got=%b exp=0", {busy, transfer, read, write, rsp_err}); end
    n_cmp++; if ({WSTRB, apb_waddr, apb_raddr, apb_wdata, rsp_rdata} !== '0) begin n_bad++; $display("FAIL rst_data got=nonzero exp=0"); end
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    set_req(0, 1'b1, 32'h00, 32'hA5, 4'h1);
    n_cmp++; if (gnt !== 2'b00) begin n_bad++; $display("FAIL wr_pre_gnt got=%h exp=0", gnt); end
    tick();
    n_cmp++; if (gnt !== 2'b01) begin n_bad++; $display("FAIL wr_gnt got=%h exp=1", gnt); end
    n_cmp++; if ({busy, transfer, write, read} !== 4'b1110) begin n_bad++; $display("FAIL wr_ctl got=%b exp=1110", {busy, transfer, write, read}); end
    n_cmp++; if (WSTRB !== 4'h1) begin n_bad++; $display("FAIL wr_strb got=%h exp=1", WSTRB); end
    n_cmp++; if (apb_wdata !== 32'hA5) begin n_bad++; $display("FAIL wr_wdata got=%h exp=a5", apb_wdata); end
    n_cmp++; if (apb_waddr !== 32'h0 || apb_raddr !== 32'h0) begin n_bad++; $display("FAIL wr_addr got=%h/%h exp=0/0", apb_waddr, apb_raddr); end
    req = '0;
    serve(XFER_HOLD + 1, 32'hDEADBEEF, 1'b0);
    n_cmp++; if (xn !== XFER_HOLD) begin n_bad++; $display("FAIL wr_xfer_len got=%0d exp=%0d", xn, XFER_HOLD); end
    n_cmp++; if (dc !== XFER_HOLD + 3) begin n_bad++; $display("FAIL wr_latency got=%0d exp=%0d", dc, XFER_HOLD + 3); end
    n_cmp++; if (dv !== 2'b01 || dn !== 1) begin n_bad++; $display("FAIL wr_done got=%h x%0d exp=1 x1", dv, dn); end
    n_cmp++; if (rdv !== 32'h0 || rev !== 1'b0) begin n_bad++; $display("FAIL wr_rsp got=%h/%b exp=0/0", rdv, rev); end
    n_cmp++; if (busy !== 1'b0 || gb !== 0) begin n_bad++; $display("FAIL wr_end got=busy%b gbad%0d exp=0/0", busy, gb); end
  endtask

  task automatic test_single_read();
    set_req(1, 1'b0, 32'h04, 32'hFFFFFFFF, 4'hF);
    tick();
    n_cmp++; if (gnt !== 2'b10) begin n_bad++; $display("FAIL rd_gnt got=%h exp=2", gnt); end
    n_cmp++; if ({transfer, read, write} !== 3'b110) begin n_bad++; $display("FAIL rd_ctl got=%b exp=110", {transfer, read, write}); end
    n_cmp++; if (apb_raddr !== 32'h04 || apb_waddr !== 32'h0) begin n_bad++; $display("FAIL rd_addr got=%h/%h exp=4/0", apb_raddr, apb_waddr); end
    n_cmp++; if (WSTRB !== 4'h0 || apb_wdata !== 32'h0) begin n_bad++; $display("FAIL rd_strb got=%h/%h exp=0/0", WSTRB, apb_wdata); end
    req = '0;
    serve(XFER_HOLD + 1, 32'h3C, 1'b0);
    n_cmp++; if (dv !== 2'b10 || dn !== 1) begin n_bad++; $display("FAIL rd_done got=%h x%0d exp=2 x1", dv, dn); end
    n_cmp++; if (rdv !== 32'h3C || rev !== 1'b0) begin n_bad++; $display("FAIL rd_rsp got=%h/%b exp=3c/0", rdv, rev); end
    n_cmp++; if (dc !== XFER_HOLD + 3) begin n_bad++; $display("FAIL rd_latency got=%0d exp=%0d", dc, XFER_HOLD + 3); end
  endtask

  task automatic test_contention();
    int idle;
    int w;
    logic [1:0] expg;
    set_req(0, 1'b1, 32'h00, 32'h11, 4'hF);
    set_req(1, 1'b1, 32'h08, 32'h22, 4'h3);
    for (int t = 0; t < 4; t++) begin
      idle = 0; w = 0;
      while (gnt == '0 && w < 20) begin
        if (!busy) idle++;
        tick();
        w++;
      end
      expg = (t % 2 == 1) ? 2'b10 : 2'b01;
      n_cmp++; if (gnt !== expg) begin n_bad++; $display("FAIL cont_gnt%0d got=%h exp=%h", t, gnt, expg); end
      n_cmp++; if (idle !== 1) begin n_bad++; $display("FAIL cont_gap%0d got=%0d exp=1", t, idle); end
      n_cmp++; if (apb_waddr !== ((t % 2 == 1) ? 32'h08 : 32'h00)) begin n_bad++; $display("FAIL cont_addr%0d got=%h", t, apb_waddr); end
      serve(XFER_HOLD + 1, 32'h0, 1'b0);
      n_cmp++; if (dv !== expg || dc !== XFER_HOLD + 3 || gb !== 0) begin n_bad++; $display("FAIL cont_done%0d got=%h@%0d gbad%0d exp=%h@%0d", t, dv, dc, gb, expg, XFER_HOLD + 3); end
    end
    req = '0;
    tick();
  endtask

  task automatic test_slave_error();
    set_req(0, 1'b1, 32'h08, 32'h05, 4'h1);
    tick();
    n_cmp++; if (gnt !== 2'b01 || apb_waddr !== 32'h08) begin n_bad++; $display("FAIL err_gnt got=%h/%h exp=1/8", gnt, apb_waddr); end
    req = '0;
    serve(XFER_HOLD + 1, 32'h0, 1'b1);
    n_cmp++; if (dv !== 2'b01 || rev !== 1'b1) begin n_bad++; $display("FAIL err_rsp got=%h/%b exp=1/1", dv, rev); end
    set_req(1, 1'b0, 32'h10, 32'h0, 4'h0);
    tick();
    req = '0;
    serve(XFER_HOLD + 1, 32'h77, 1'b0);
    n_cmp++; if (dv !== 2'b10 || rev !== 1'b0 || rdv !== 32'h77) begin n_bad++; $display("FAIL err_next got=%h/%b/%h exp=2/0/77", dv, rev, rdv); end
    n_cmp++; if (rsp_rdata !== 32'h77) begin n_bad++; $display("FAIL err_hold got=%h exp=77", rsp_rdata); end
  endtask

  task automatic test_timeout();
    set_req(0, 1'b0, 32'h0C, 32'h0, 4'h0);
    tick();
    n_cmp++; if (gnt !== 2'b01) begin n_bad++; $display("FAIL to_gnt got=%h exp=1", gnt); end
    req = '0;
    serve(-1, 32'h0, 1'b0);
    n_cmp++; if (dc !== XFER_HOLD + TIMEOUT) begin n_bad++; $display("FAIL to_latency got=%0d exp=%0d", dc, XFER_HOLD + TIMEOUT); end
    n_cmp++; if (dv !== 2'b01 || rev !== 1'b1 || rdv !== 32'h0) begin n_bad++; $display("FAIL to_rsp got=%h/%b/%h exp=1/1/0", dv, rev, rdv); end
    n_cmp++; if (busy !== 1'b0 || dn !== 1) begin n_bad++; $display("FAIL to_idle got=busy%b x%0d exp=0 x1", busy, dn); end
  endtask

  task automatic test_issue_done();
    set_req(1, 1'b1, 32'h20, 32'h99, 4'hF);
    tick();
    n_cmp++; if (gnt !== 2'b10) begin n_bad++; $display("FAIL iss_gnt got=%h exp=2", gnt); end
    req = '0;
    serve(1, 32'h0, 1'b0);
    n_cmp++; if (xn !== XFER_HOLD) begin n_bad++; $display("FAIL iss_xfer_len got=%0d exp=%0d", xn, XFER_HOLD); end
    n_cmp++; if (dc !== XFER_HOLD + 1 || dv !== 2'b10 || rev !== 1'b0) begin n_bad++; $display("FAIL iss_done got=%h@%0d err%b exp=2@%0d err0", dv, dc, rev, XFER_HOLD + 1); end
  endtask

  task automatic test_reset_mid_wait();
    int dcount;
    set_req(0, 1'b0, 32'h14, 32'h0, 4'h0);
    tick();
    n_cmp++; if (gnt !== 2'b01) begin n_bad++; $display("FAIL rmw_gnt got=%h exp=1", gnt); end
    for (int i = 0; i < XFER_HOLD; i++) tick();
    n_cmp++; if (busy !== 1'b1 || transfer !== 1'b0 || apb_raddr !== 32'h14) begin n_bad++; $display("FAIL rmw_wait got=%b%b/%h exp=10/14", busy, transfer, apb_raddr); end
    set_req(1, 1'b0, 32'h18, 32'h0, 4'h0);
    PRESETn = 1'b0;
    #1;
    n_cmp++; if ({gnt, done, busy, transfer, read, write} !== '0) begin n_bad++; $display("FAIL rmw_ctl got=%b exp=0", {gnt, done, busy, transfer, read, write}); end
    n_cmp++; if ({apb_raddr, apb_waddr, WSTRB, apb_wdata, rsp_rdata, rsp_err} !== '0) begin n_bad++; $display("FAIL rmw_data got=nonzero exp=0"); end
    dcount = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done != '0) dcount++;
    end
    n_cmp++; if (dcount !== 0) begin n_bad++; $display("FAIL rmw_no_done got=%0d exp=0", dcount); end
    PRESETn = 1'b1;
    tick();
    n_cmp++; if (gnt !== 2'b01 || apb_raddr !== 32'h14) begin n_bad++; $display("FAIL rmw_rearb got=%h/%h exp=1/14", gnt, apb_raddr); end
    req = '0;
    serve(XFER_HOLD + 1, 32'h5A, 1'b0);
    n_cmp++; if (dv !== 2'b01 || rdv !== 32'h5A || dc !== XFER_HOLD + 3) begin n_bad++; $display("FAIL rmw_done got=%h/%h@%0d exp=1/5a@%0d", dv, rdv, dc, XFER_HOLD + 3); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_contention();
    test_slave_error();
    test_timeout();
    test_issue_done();
    test_reset_mid_wait();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
